pipelined_shift_unit: RTL
=========================

Name: pipelined_shift_unit

Overview:
- Parametrised, pipelined barrel shifter for the execute stage; successor to the single-mode combinational arithmetic right shifter.
- Supports SLL, SRL and SRA, plus RV64 word forms (SLLW/SRLW/SRAW).
- Log-shifter levels are spread over STAGES register stages.
- Valid/ready handshake on both sides, full throughput, backpressure and flush.

Parameters:
- XLEN, 64, operand/result width; 32 or 64.
- STAGES, 2, register stages (1..log2(XLEN)); equals latency in cycles.
- TAG_W, 5, width of the sideband tag carried with each operation (e.g. rd index).
- SHAMT_W, $clog2(XLEN), derived localparam; not overridable.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all in-flight operations
- in_valid  in  1  operation offered
- in_ready  out  1  unit accepts this cycle
- in_data  in  XLEN  operand
- in_shamt  in  SHAMT_W  shift amount
- in_op  in  2  00 SLL, 01 SRL, 11 SRA, 10 pass-through
- in_word  in  1  32-bit word op (honoured only when XLEN==64, else ignored)
- in_tag  in  TAG_W  sideband, returned unchanged
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_data  out  XLEN  result
- out_tag  out  TAG_W  tag of result

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage valid bits cleared; out_valid=0, out_data=0, out_tag=0.
  - in_ready=1 once reset deasserts.
- Transfer rules:
  - Input transfer when in_valid and in_ready are both 1.
  - Output transfer when out_valid and out_ready are both 1.
- Stage advance:
  - Stage k advances when it is empty or stage k+1 accepts.
  - The last stage advances when it is empty or out_ready=1.
  - in_ready = stage0 empty OR stage0 advancing, so a full pipeline with out_ready=1 accepts one operation per cycle.
- Stall: when out_ready=0 and the pipeline is full, all stages hold their data and in_ready=0. No data is dropped or duplicated.
- Latency: a result accepted at edge N is presented at out_* after edge N+STAGES-1 (registered output), provided there are no stalls.
- Level distribution:
  - log2(XLEN) levels; level j shifts by 2^j, controlled by shamt bit j.
  - Stage s performs levels [s*L, min((s+1)*L, log2 XLEN)), where L = ceil(log2(XLEN)/STAGES).
  - Remaining shamt bits, op, word flag and tag are piped alongside the data.
- Left shift: may be implemented by bit-reversing before and after a right shift. The result must equal a logical left shift with zero fill.
- Full-width mode (in_word=0): effective shamt = in_shamt[SHAMT_W-1:0].
  - SRA fills with in_data[XLEN-1].
  - SRL and SLL fill with zeros.
- Word mode (in_word=1, XLEN==64):
  - Only in_data[31:0] is used; effective shamt = in_shamt[4:0] (bit 5 ignored).
  - SRA fills with bit 31; SRL/SLL fill with zeros.
  - The 32-bit result is sign-extended from bit 31 to 64 bits.
- Pass-through (op 10): out_data = in_data (word mode: sign-extended low word). Same latency as shifts.
- Boundary cases:
  - shamt=0 returns the operand unchanged (word mode: sign-extended).
  - shamt=XLEN-1 for SRA yields all-sign-bits.
- Flush:
  - Clears every stage valid and out_valid at the next edge.
  - Takes priority over a simultaneous input or output transfer: in_ready is forced to 0 during flush, and no operation accepted in that cycle survives.
  - Data registers need not be cleared.
- Data/tag registers load only on advance; they hold otherwise.

Decomposition:
- Package shift_pkg: op encoding constants (OP_SLL, OP_SRL, OP_PASS, OP_SRA) and the stage payload struct (data, remaining shamt, op, word, tag).
- Sub-module shift_stage: one register stage with parameters FIRST_LVL and NUM_LVL. It applies its levels combinationally, then registers the payload and valid with the advance handshake.
- The top level instantiates STAGES copies of shift_stage and performs the word-mode pre/post processing.

Test Plan:
- SRA full: in_data=64'h8000_0000_0000_00F0, shamt=4, op=11 -> out_data=64'hF800_0000_0000_000F after STAGES cycles; out_tag matches in_tag.
- SRAW: in_data=64'h0000_0000_8000_0000, shamt=6'd33 (word, bit5 ignored → 1), op=11 -> out_data=64'hFFFF_FFFF_C000_0000.
- SLLW/SRLW: in_data=64'hFFFF_FFFF_0000_0001, shamt=31, SLL word -> 64'hFFFF_FFFF_8000_0000; SRL word of 64'h0000_0000_8000_0000 by 31 -> 64'h1.
- Backpressure: stream 8 ops back-to-back with out_ready low for 3 cycles mid-stream -> in_ready drops once the pipeline is full; all 8 results emerge in order, none lost or repeated; throughput 1/cycle before and after the stall.
- Flush: 2 ops in flight, assert flush for 1 cycle with in_valid=1 -> out_valid=0 the next cycle; no result with those tags ever appears; the next op returns after STAGES cycles.
- Async reset: assert rst_n=0 mid-stream between clock edges -> out_valid=0 and out_data=0 immediately; after release, in_ready=1 and a shamt=0 op returns in_data unchanged.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the pipelined shift unit: operation encoding and the
// per-stage control payload carried alongside data, shift amount and tag.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_PASS = 2'b10,
    OP_SRA  = 2'b11
  } op_e;

  typedef struct packed {
    op_e  op;
    logic word;
  } ctrl_t;

endpackage

// File: rtl/shift_stage.sv
// One register stage of the log shifter: applies a contiguous range of right-shift
// levels combinationally, then registers the payload under the valid/ready handshake.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned TAG_W     = 5,
  parameter int unsigned SHAMT_W   = 6,
  parameter int unsigned FIRST_LVL = 0,
  parameter int unsigned NUM_LVL   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [XLEN-1:0]    data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  ctrl_t              ctrl_i,
  input  logic [TAG_W-1:0]   tag_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [XLEN-1:0]    data_o,
  output logic [SHAMT_W-1:0] shamt_o,
  output ctrl_t              ctrl_o,
  output logic [TAG_W-1:0]   tag_o
);

  logic [XLEN-1:0] lvl [NUM_LVL+1];
  logic            fill;
  logic            advance;
  logic [XLEN-1:0] data_d;

  logic               valid_q;
  logic [XLEN-1:0]    data_q;
  logic [SHAMT_W-1:0] shamt_q;
  ctrl_t              ctrl_q;
  logic [TAG_W-1:0]   tag_q;

  // Arithmetic shifts never change the MSB, so the sign is still at the top here.
  assign fill   = (ctrl_i.op == OP_SRA) & data_i[XLEN-1];
  assign lvl[0] = data_i;

  for (genvar g = 0; g < NUM_LVL; g++) begin : g_lvl
    localparam int unsigned Amt = 1 << (FIRST_LVL + g);
    assign lvl[g+1] = shamt_i[FIRST_LVL+g] ?
                      (fill ? ~(~lvl[g] >> Amt) : (lvl[g] >> Amt)) : lvl[g];
  end

  assign data_d  = lvl[NUM_LVL];
  assign advance = !valid_q || ready_i;
  assign ready_o = advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      ctrl_q  <= '{op: OP_SLL, word: 1'b0};
      tag_q   <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (advance) begin
        valid_q <= valid_i;
      end
      if (advance && valid_i) begin
        data_q  <= data_d;
        shamt_q <= shamt_i;
        ctrl_q  <= ctrl_i;
        tag_q   <= tag_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign shamt_o = shamt_q;
  assign ctrl_o  = ctrl_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/pipelined_shift_unit.sv
// Pipelined SLL/SRL/SRA barrel shifter with RV64 word forms. Left shifts run as
// right shifts on bit-reversed data; word ops are narrowed before and widened after.
module pipelined_shift_unit
  import shift_pkg::*;
#(
  parameter  int unsigned XLEN    = 64,
  parameter  int unsigned STAGES  = 2,
  parameter  int unsigned TAG_W   = 5,
  localparam int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic               in_word,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int unsigned LvlPerStage = (SHAMT_W + STAGES - 1) / STAGES;

  // Index s is the input of stage s; index STAGES is the last stage's output.
  logic               v   [STAGES+1];
  logic               rdy [STAGES+1];
  logic [XLEN-1:0]    d   [STAGES+1];
  logic [SHAMT_W-1:0] sh  [STAGES+1];
  ctrl_t              c   [STAGES+1];
  logic [TAG_W-1:0]   t   [STAGES+1];

  op_e                in_op_e;
  logic               is_word;
  logic [XLEN-1:0]    word_data;
  logic [XLEN-1:0]    word_rev;
  logic [SHAMT_W-1:0] word_shamt;
  logic [XLEN-1:0]    res;
  logic [XLEN-1:0]    res_rev;
  logic               unused_shamt;

  assign in_op_e = op_e'(in_op);

  if (XLEN == 64) begin : g_rv64
    // SRAW needs the word sign replicated so the 64-bit shift fills with bit 31.
    assign is_word    = in_word;
    assign word_data  = !in_word ? in_data :
                        (in_op_e == OP_SRA) ? {{32{in_data[31]}}, in_data[31:0]} :
                                              {32'b0, in_data[31:0]};
    assign word_shamt = in_word ? {1'b0, in_shamt[4:0]} : in_shamt;
    assign out_data   = c[STAGES].word ? {{32{res[31]}}, res[31:0]} : res;
  end else begin : g_rv32
    logic unused_word;
    assign unused_word = in_word;
    assign is_word     = 1'b0;
    assign word_data   = in_data;
    assign word_shamt  = in_shamt;
    assign out_data    = res;
  end

  assign word_rev = {<<{word_data}};

  assign v[0]   = in_valid;
  assign d[0]   = (in_op_e == OP_SLL) ? word_rev : word_data;
  assign sh[0]  = (in_op_e == OP_PASS) ? '0 : word_shamt;
  assign c[0]   = '{op: in_op_e, word: is_word};
  assign t[0]   = in_tag;
  assign rdy[STAGES] = out_ready;

  // A flush cycle must not admit anything, since the op would be killed anyway.
  assign in_ready = rdy[0] && !flush;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned First = s * LvlPerStage;
    localparam int unsigned Num   = (First >= SHAMT_W) ? 0 :
                                    ((SHAMT_W - First < LvlPerStage) ? SHAMT_W - First :
                                                                       LvlPerStage);
    shift_stage #(
      .XLEN     (XLEN),
      .TAG_W    (TAG_W),
      .SHAMT_W  (SHAMT_W),
      .FIRST_LVL(First),
      .NUM_LVL  (Num)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .valid_i(v[s]),
      .ready_o(rdy[s]),
      .data_i (d[s]),
      .shamt_i(sh[s]),
      .ctrl_i (c[s]),
      .tag_i  (t[s]),
      .valid_o(v[s+1]),
      .ready_i(rdy[s+1]),
      .data_o (d[s+1]),
      .shamt_o(sh[s+1]),
      .ctrl_o (c[s+1]),
      .tag_o  (t[s+1])
    );
  end

  assign res_rev      = {<<{d[STAGES]}};
  assign res          = (c[STAGES].op == OP_SLL) ? res_rev : d[STAGES];
  assign out_valid    = v[STAGES];
  assign out_tag      = t[STAGES];
  assign unused_shamt = ^sh[STAGES];

endmodule
